// File: rtl/ifu_fetch.sv
// ---------------------------------------------------------------------------
// ifu_fetch -- single-outstanding-request instruction fetch unit.
//
// Fetches one 32-bit instruction at a time. The instruction is held for
// decode until it is consumed. When it is consumed, the PC moves on
// sequentially (PC+4) or is redirected to a jump/branch target.
//
// Ports
//   clk, rst              clock; asynchronous active-high reset
//   imem_req_o/addr_o     fetch request and address (current PC)
//   imem_ready_i          memory accepts the request this cycle
//   imem_rvalid_i/rdata_i returned instruction word
//   inst_valid_o/ready_i  held instruction handshake towards decode
//   inst_o, pc_o          held instruction and its PC
//   opcode_o/func3_o/func7_o  decoded fields of inst_o for the control unit
//   pcsel_i, target_i     redirect request and target (sampled on consume)
//   misalign_o            sticky: some redirect target was not 4-byte aligned
// ---------------------------------------------------------------------------
module ifu_fetch #(
    parameter int                XLEN     = 64,
    parameter logic [XLEN-1:0]   RESET_PC = 64'h8000_0000
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic            imem_ready_i,
    input  logic            imem_rvalid_i,
    input  logic [31:0]     imem_rdata_i,
    output logic            inst_valid_o,
    input  logic            inst_ready_i,
    output logic [31:0]     inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [6:0]      opcode_o,
    output logic [2:0]      func3_o,
    output logic [6:0]      func7_o,
    input  logic            pcsel_i,
    input  logic [XLEN-1:0] target_i,
    output logic            misalign_o
);

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [31:0]     r_inst;
    logic [XLEN-1:0] r_inst_pc;
    logic            r_misalign;

    logic            w_capture;   // returned word is latched this cycle
    logic            w_consume;   // decode takes the held instruction
    logic [XLEN-1:0] w_target_aligned;

    assign w_capture        = (r_state == WAIT) && imem_rvalid_i;
    assign w_consume        = (r_state == HOLD) && inst_ready_i;
    assign w_target_aligned = {target_i[XLEN-1:2], 2'b00};

    // Next-state logic. rvalid outside WAIT never reaches here, so a stray
    // response (e.g. the tail of a request discarded by reset) is dropped.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            FETCH:   if (imem_ready_i)  w_state_next = WAIT;
            WAIT:    if (imem_rvalid_i) w_state_next = HOLD;
            HOLD:    if (inst_ready_i)  w_state_next = FETCH;
            default:                    w_state_next = FETCH;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= FETCH;
            r_pc       <= RESET_PC;
            r_inst     <= NOP;
            r_inst_pc  <= RESET_PC;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_capture) begin
                r_inst    <= imem_rdata_i;
                r_inst_pc <= r_pc;
            end
            if (w_consume) begin
                if (pcsel_i) begin
                    r_pc <= w_target_aligned;
                    if (target_i[1:0] != 2'b00) begin
                        r_misalign <= 1'b1;
                    end
                end else begin
                    // Natural wrap at 2^XLEN.
                    r_pc <= r_pc + XLEN'(4);
                end
            end
        end
    end

    // The state register already sits in FETCH while rst is high, so the
    // request is also gated by rst to keep it quiet during reset.
    assign imem_req_o   = (r_state == FETCH) && !rst;
    assign imem_addr_o  = r_pc;
    assign inst_valid_o = (r_state == HOLD) && !rst;
    assign inst_o       = r_inst;
    assign pc_o         = r_inst_pc;
    assign opcode_o     = r_inst[6:0];
    assign func3_o      = r_inst[14:12];
    assign func7_o      = r_inst[31:25];
    assign misalign_o   = r_misalign;

endmodule

// File: doc/ifu_fetch.md
IFU_FETCH -- requirements
Module: ifu_fetch

Interface
REQ-001 SHALL have parameter: XLEN, 64, width of PC and redirect target.
REQ-002 SHALL have parameter: RESET_PC, 64'h8000_0000, PC value loaded on reset.
REQ-003 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port: rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port: imem_req_o  output  1  fetch request valid.
REQ-006 SHALL have port: imem_addr_o  output  XLEN  fetch address (current PC).
REQ-007 SHALL have port: imem_ready_i  input  1  memory accepts request this cycle.
REQ-008 SHALL have port: imem_rvalid_i  input  1  read data valid.
REQ-009 SHALL have port: imem_rdata_i  input  32  fetched instruction word.
REQ-010 SHALL have port: inst_valid_o  output  1  instruction held for decode.
REQ-011 SHALL have port: inst_ready_i  input  1  decode/execute consumes instruction this cycle.
REQ-012 SHALL have port: inst_o  output  32  held instruction.
REQ-013 SHALL have port: pc_o  output  XLEN  PC of held instruction.
REQ-014 SHALL have port: opcode_o / func3_o / func7_o  output  7/3/7  inst_o[6:0] / [14:12] / [31:25], fed to cu.
REQ-015 SHALL have port: pcsel_i  input  1  redirect request (taken jump/branch).
REQ-016 SHALL have port: target_i  input  XLEN  redirect target.
REQ-017 SHALL have port: misalign_o  output  1  sticky flag: redirect target not 4-byte aligned.

Function
REQ-018 SHALL implement FSM states FETCH, WAIT, HOLD.
REQ-019 FETCH: imem_req_o=1, imem_addr_o=PC; imem_ready_i=1 -> WAIT, else stay.
REQ-020 WAIT: imem_req_o=0; imem_rvalid_i=1 -> latch imem_rdata_i into inst register, latch PC into pc register, -> HOLD.
REQ-021 HOLD: inst_valid_o=1; inst_ready_i=1 with pcsel_i=0 -> PC<=PC+4, -> FETCH.
REQ-022 inst_valid_o SHALL be 1 only in HOLD; inst_o/pc_o/field outputs SHALL be stable while in HOLD.
REQ-023 Minimum latency request-to-inst_valid_o: 2 cycles (FETCH accepted, rvalid next cycle in WAIT).
REQ-024 pcsel_i SHALL be sampled only in HOLD with inst_ready_i=1; then PC<=target_i with bits [1:0] forced to 0, -> FETCH.
REQ-025 pcsel_i in HOLD with inst_ready_i=0 SHALL be ignored.
REQ-026 PC+4 SHALL wrap modulo 2^XLEN (all-ones-minus-3 -> 0).
REQ-027 Redirect with target_i[1:0]!=0 SHALL set misalign_o; misalign_o SHALL stay 1 until reset.
REQ-028 imem_rvalid_i in FETCH or HOLD SHALL be ignored (no state or data change).
REQ-029 imem_req_o SHALL never be asserted outside FETCH; at most one outstanding request.

Reset
REQ-030 rst=1 SHALL immediately (asynchronously) force state FETCH, PC=RESET_PC, inst register=32'h0000_0013 (nop), pc register=RESET_PC, misalign_o=0.
REQ-031 During reset: imem_req_o=0, inst_valid_o=0; imem_req_o SHALL assert in the first cycle after rst deasserts.
REQ-032 Reset in WAIT SHALL discard the outstanding request; a late imem_rvalid_i after reset SHALL be ignored (arrives in FETCH).

Verification
REQ-033 Reset release, imem_ready_i=1, rvalid next cycle with 32'h0010_0093 -> imem_addr_o=0x8000_0000, inst_valid_o=1 two cycles later, opcode_o=7'b0010011, func3_o=3'b000, pc_o=0x8000_0000.
REQ-034 Three back-to-back fetches, inst_ready_i=1 -> imem_addr_o sequence 0x8000_0000, 0x8000_0004, 0x8000_0008.
REQ-035 HOLD, inst_ready_i=0 for 5 cycles with pcsel_i toggling -> inst_o/pc_o unchanged, no imem_req_o, PC not redirected.
REQ-036 HOLD, inst_ready_i=1, pcsel_i=1, target_i=0x8000_0102 -> next imem_addr_o=0x8000_0100, misalign_o=1 and stays 1.
REQ-037 imem_ready_i held 0 for 4 cycles -> imem_req_o=1 with constant address throughout; rst pulse in WAIT then stray rvalid -> no inst_valid_o, next fetch at 0x8000_0000.
REQ-038 PC=64'hFFFF_FFFF_FFFF_FFFC via redirect, consume -> next imem_addr_o=0.
